// File: rtl/menu_controller.sv
// Screen sequencer: samples buttons once per frame, owns the homescreen cursor,
// the active screen mode and the colour theme used by the homescreen renderer.
module menu_controller #(
  parameter int HOLD_FRAMES   = 30,
  parameter int REPEAT_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        screenEnd,
  input  logic [7:0]  buttons,
  output logic [1:0]  sel,
  output logic [1:0]  mode,
  output logic        home_en,
  output logic        game_en,
  output logic [1:0]  theme,
  output logic [11:0] color0,
  output logic [11:0] color1
);

  typedef enum logic [1:0] {
    MODE_HOME = 2'b00,
    MODE_GAME = 2'b01,
    MODE_CTRL = 2'b10,
    MODE_STGS = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_A,
    ACT_B,
    ACT_UP,
    ACT_DOWN,
    ACT_LEFT,
    ACT_RIGHT
  } act_t;

  localparam logic [1:0] SEL_GAME = 2'b00;
  localparam logic [1:0] SEL_CTRL = 2'b01;
  localparam logic [1:0] SEL_STGS = 2'b10;

  localparam logic [7:0] HOLD_MAX = 8'(HOLD_FRAMES);
  localparam logic [7:0] REP_MAX  = 8'(REPEAT_FRAMES);

  mode_t      state;
  logic [7:0] prev;
  logic [7:0] hold_cnt;
  logic [7:0] rep_cnt;

  logic [3:0] dirs;
  logic [7:0] press;
  logic [7:0] hold_nxt;
  logic [7:0] rep_nxt;
  logic       rep_fire;
  logic       rep_ok;
  logic [5:0] ev;
  act_t       act;

  assign dirs   = buttons[3:0];
  assign press  = buttons & ~prev;
  assign rep_ok = (state == MODE_HOME) || (state == MODE_STGS);

  // hold_cnt counts consecutive samples of the same non-zero direction
  // pattern, the first sample counting as 1, so the first repeat lands
  // HOLD_FRAMES-1 frames after the press.
  always_comb begin
    hold_nxt = '0;
    rep_nxt  = '0;
    rep_fire = 1'b0;
    if (dirs != 4'b0000) begin
      if (dirs == prev[3:0]) begin
        if (hold_cnt == HOLD_MAX) begin
          hold_nxt = hold_cnt;
          if (rep_cnt == REP_MAX - 8'd1) begin
            rep_fire = 1'b1;
          end else begin
            rep_nxt = rep_cnt + 8'd1;
          end
        end else begin
          hold_nxt = hold_cnt + 8'd1;
          rep_fire = (hold_cnt + 8'd1 == HOLD_MAX);
        end
      end else begin
        hold_nxt = 8'd1;
        rep_fire = (HOLD_MAX == 8'd1);
      end
    end
  end

  // A repeat counts as a fresh press of every held direction.
  assign ev = {press[5:4], press[3:0] | ((rep_fire && rep_ok) ? dirs : 4'b0000)};

  always_comb begin
    act = ACT_NONE;
    if (ev[4])      act = ACT_A;
    else if (ev[5]) act = ACT_B;
    else if (ev[0]) act = ACT_UP;
    else if (ev[1]) act = ACT_DOWN;
    else if (ev[2]) act = ACT_LEFT;
    else if (ev[3]) act = ACT_RIGHT;
  end

  // screenEnd is the sole update strobe: state advances only on an edge where
  // it is high, outputs reflect it from the next cycle; there is no back-pressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= MODE_HOME;
      sel      <= SEL_GAME;
      theme    <= 2'd0;
      prev     <= '0;
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else if (screenEnd) begin
      prev     <= buttons;
      hold_cnt <= hold_nxt;
      rep_cnt  <= rep_nxt;
      case (state)
        MODE_HOME: begin
          case (act)
            ACT_A:     state <= mode_t'(sel + 2'd1);
            ACT_UP:    if (sel == SEL_CTRL || sel == SEL_STGS) sel <= SEL_GAME;
            ACT_DOWN:  if (sel == SEL_GAME) sel <= SEL_CTRL;
            ACT_LEFT:  if (sel == SEL_STGS) sel <= SEL_CTRL;
            ACT_RIGHT: if (sel == SEL_CTRL) sel <= SEL_STGS;
            default:   ;
          endcase
        end
        MODE_GAME: begin
          if (buttons[6] && buttons[7] && (press[6] || press[7])) state <= MODE_HOME;
        end
        MODE_CTRL: begin
          if (act == ACT_B) state <= MODE_HOME;
        end
        MODE_STGS: begin
          case (act)
            ACT_B:     state <= MODE_HOME;
            ACT_RIGHT: theme <= theme + 2'd1;
            ACT_LEFT:  theme <= theme - 2'd1;
            default:   ;
          endcase
        end
        default: state <= MODE_HOME;
      endcase
    end
  end

  assign mode    = state;
  assign home_en = (state == MODE_HOME);
  assign game_en = (state == MODE_GAME);

  always_comb begin
    color0 = 12'hFFF;
    color1 = 12'h000;
    case (theme)
      2'd0: begin color0 = 12'hFFF; color1 = 12'h000; end
      2'd1: begin color0 = 12'h0F0; color1 = 12'h020; end
      2'd2: begin color0 = 12'hFA0; color1 = 12'h310; end
      2'd3: begin color0 = 12'h0CF; color1 = 12'h005; end
      default: ;
    endcase
  end

endmodule

// File: doc/menu_controller.md
Name: menu_controller

Overview:
- Top-level screen sequencer for the console graphics path.
- Samples controller buttons once per frame and owns the homescreen cursor (sel).
- Decides which screen mode currently drives VGA: HOME, GAME, CTRL or SETTINGS.
- Holds the colour theme that supplies the trim/background colours (color0/color1) to the homescreen renderer, replacing the standalone homescreen FSM.

Parameters:
- HOLD_FRAMES, 30, frames a direction must be held before auto-repeat starts; legal range 1..255.
- REPEAT_FRAMES, 8, frames between auto-repeat events once repeating; legal range 1..255.

Ports:
- clk  in  1  100 MHz system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- screenEnd  in  1  one-clk-cycle pulse at each frame boundary, already in the clk domain.
- buttons  in  8  level inputs: [0] up, [1] down, [2] left, [3] right, [4] A, [5] B, [6] start, [7] select.
- sel  out  2  homescreen cursor: 00 GAME, 01 CTRL, 10 STGS; 11 never driven.
- mode  out  2  active screen: 00 HOME, 01 GAME, 10 CTRL, 11 STGS.
- home_en  out  1  high iff mode==HOME.
- game_en  out  1  high iff mode==GAME.
- theme  out  2  current theme index.
- color0  out  12  trim colour of the current theme.
- color1  out  12  background colour of the current theme.

Behaviour:
- Reset: mode=HOME, sel=00, theme=0, prev-sample register=0, hold_cnt=0, rep_cnt=0. Outputs are valid from the cycle after reset deasserts. Reset mid-operation discards any pending event.
- Sampling: buttons are observed only in a cycle where screenEnd=1. All state updates happen on that edge; outputs change the following cycle (1-cycle latency). No state changes between pulses.
- Press event: bit sampled 1 and previously sampled 0. prev-sample updates on every screenEnd, in every mode.
- Auto-repeat, direction bits [3:0] only:
  - hold_cnt increments (saturating at HOLD_FRAMES) on each screenEnd where dirs!=0 and dirs equal the previous sample.
  - Otherwise hold_cnt=0 and rep_cnt=0.
  - The first repeat fires on the sample at which hold_cnt reaches HOLD_FRAMES.
  - After that, rep_cnt counts 1..REPEAT_FRAMES, and a repeat fires and rep_cnt clears on reaching REPEAT_FRAMES.
  - A repeat acts as a press of every held direction.
  - Repeats are honoured only in HOME and STGS.
- One action per frame, priority A > B > up > down > left > right; lower-priority events that frame are dropped.
- HOME transitions:
  - A: mode <= sel+1.
  - down: GAME->CTRL.
  - up: CTRL/STGS->GAME.
  - right: CTRL->STGS.
  - left: STGS->CTRL.
  - Every other direction/cursor combination leaves sel unchanged (no wrap).
  - B is ignored.
- GAME: returns to HOME only when start and select are both sampled 1 and at least one of them is a press event this frame. All other buttons are ignored here; they belong to the game.
- CTRL: B returns to HOME; everything else is ignored.
- STGS:
  - B returns to HOME.
  - right: theme <= theme+1, wrapping 3->0.
  - left: theme <= theme-1, wrapping 0->3.
  - up/down ignored.
- sel is retained across mode changes; returning to HOME shows the last cursor.
- A button held while entering a mode does not produce a new press in that mode (prev=1).
- Theme table (color0/color1), combinational from the registered theme:
  - 0: FFF/000
  - 1: 0F0/020
  - 2: FA0/310
  - 3: 0CF/005

Test Plan:
- Reset held 3 cycles, then screenEnd pulses with buttons=0 -> mode=00, sel=00, theme=0, color0=FFF, color1=000, home_en=1, game_en=0.
- HOME: press down, then right, then up on successive frames -> sel sequence 01, 10, 00. Each change appears 1 cycle after its screenEnd; buttons toggled between pulses without screenEnd cause no change.
- HOME sel=10, press A -> mode=11. Press right 5 times (release between presses) -> theme 1,2,3,0,1 with color0=0F0 at the end. Press B -> mode=00, sel still 10.
- HOLD_FRAMES=3, REPEAT_FRAMES=2, STGS, hold right 9 frames -> theme increments at frames 1 (press), 3, 5, 7, 9. Releasing for one frame resets the counters.
- GAME: press start+select on the same frame -> mode=00 the next cycle. Start alone held, then select pressed later -> exits. A/B/directions in GAME -> no change.
- Same frame A+down in HOME with sel=00 -> mode=01 and sel stays 00. Assert reset while mode=11, theme=2 -> all state back to reset values the next cycle.
